// File: rtl/mux_key_scanner_if.sv
// Scanner-side bundle: scan request, mux select/return and the sample handshake.
// valid/ready: sample is held stable while valid=1 and moves only on an edge with valid&&ready.
interface mux_key_scanner_if;
    logic       start;
    logic [3:0] ch_mask;
    logic       mux_out;
    logic [1:0] key;
    logic [3:0] sample;
    logic       valid;
    logic       ready;
    logic       busy;

    modport master (
        input  start, ch_mask, mux_out, ready,
        output key, sample, valid, busy
    );

    modport slave (
        output start, ch_mask, mux_out, ready,
        input  key, sample, valid, busy
    );
endinterface

// File: rtl/mux_key_scanner.sv
// Steps the 4:1 mux select through the enabled channels, settles, samples mux_out into a
// capture word and offers it downstream over valid/ready. One scan per accepted start.
module mux_key_scanner #(
    parameter int SETTLE = 2,
    parameter int NCH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_key_scanner_if.master   bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int           KW       = $clog2(NCH);
    localparam logic [3:0]   SETTLE_C = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [KW-1:0]    key_q, key_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NCH-1:0]   sample_q, sample_d;
    logic             valid_q, valid_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             accept;
    logic             take;
    logic             has_next;
    logic [KW-1:0]    first_key;
    logic [KW-1:0]    next_key;

    // Descending walk: the last hit is the lowest enabled channel (above key_q for next_key).
    always_comb begin
        first_key = '0;
        next_key  = key_q;
        has_next  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) begin
                first_key = KW'(i);
            end
            if (mask_q[i] && (i > int'(key_q))) begin
                has_next = 1'b1;
                next_key = KW'(i);
            end
        end
    end

    assign accept = bus.start && (bus.ch_mask != '0);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        take     = 1'b0;

        case (state_q)
            S_IDLE: begin
                key_d = '0;
                take  = accept;
            end
            S_SEL: begin
                if (cnt_q == SETTLE_C) begin
                    sample_d[key_q] = bus.mux_out;
                    if (has_next) begin
                        key_d = next_key;
                        cnt_d = '0;
                    end else begin
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.ready) begin
                    if (accept) begin
                        take = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        key_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                key_d   = '0;
            end
        endcase

        // A new scan starts from IDLE or straight out of a completed handshake.
        if (take) begin
            mask_d   = bus.ch_mask;
            sample_d = '0;
            key_d    = first_key;
            cnt_d    = '0;
            valid_d  = 1'b0;
            state_d  = S_SEL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            mask_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.key     = key_q;
    assign bus.sample  = sample_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mux_key_scanner.sv
// Bench for mux_key_scanner: a data-word mux model drives mux_out, and each scan is compared
// against the select sequence, latency and capture word derived from the channel mask.
module tb_mux_key_scanner;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_r = 4'b0;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];

    mux_key_scanner_if bus_if ();

    assign bus_if.mux_out = data_r[bus_if.key];

    mux_key_scanner #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.master),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Expected key trace: every enabled channel, ascending, held SETTLE+1 cycles.
    function automatic void build_exp(input logic [3:0] m);
        exp_q.delete();
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int r = 0; r <= SETTLE; r++) exp_q.push_back(2'(ch));
            end
        end
    endfunction

    task automatic launch(input logic [3:0] m, input logic [3:0] d);
        @(negedge clk);
        data_r         = d;
        bus_if.ch_mask = m;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
    endtask

    // Records key each cycle until valid; lat counts edges after the accepting edge.
    task automatic collect(input int poke_at, output int lat, output bit timed_out);
        obs_q.delete();
        lat       = 0;
        timed_out = 1'b0;
        while (bus_if.valid !== 1'b1) begin
            if (lat > 200) begin
                timed_out = 1'b1;
                break;
            end
            obs_q.push_back(bus_if.key);
            if (lat == poke_at) begin
                bus_if.start   = 1'b1;
                bus_if.ch_mask = 4'b1000;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus_if.start = 1'b0;
    endtask

    task automatic ack();
        bus_if.ready = 1'b1;
        @(negedge clk);
        bus_if.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus_if.key !== 2'd0) begin n_err++; $display("FAIL reset_key got=%0d exp=0", bus_if.key); end
        n_cmp++; if (bus_if.sample !== 4'b0) begin n_err++; $display("FAIL reset_sample got=%b exp=0000", bus_if.sample); end
        n_cmp++; if (bus_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        rst_n          = 1'b1;
        bus_if.start   = 1'b1;
        bus_if.ch_mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL zero_mask_busy cyc=%0d got=%b exp=0", i, bus_if.busy); end
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_full_scan();
        int lat; bit to; int bad;
        launch(4'b1111, 4'b1010);
        build_exp(4'b1111);
        collect(-1, lat, to);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL full_timeout got=1 exp=0"); end
        n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL full_latency got=%0d exp=12", lat); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL full_key_seq bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (bus_if.sample !== 4'b1010) begin n_err++; $display("FAIL full_sample got=%b exp=1010", bus_if.sample); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.sample !== 4'b1010 || bus_if.valid !== 1'b1) begin
                n_err++; $display("FAIL full_hold cyc=%0d got=%b/%b exp=1010/1", i, bus_if.sample, bus_if.valid);
            end
        end
        ack();
        n_cmp++; if (bus_if.valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.key !== 2'd0) begin
            n_err++; $display("FAIL full_release got=v%b b%b k%0d exp=v0 b0 k0", bus_if.valid, bus_if.busy, bus_if.key);
        end
    endtask

    task automatic test_sparse();
        int lat; bit to; int bad;
        launch(4'b0101, 4'b1111);
        build_exp(4'b0101);
        collect(-1, lat, to);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (lat !== 6 || to) begin n_err++; $display("FAIL sparse_latency got=%0d exp=6", lat); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL sparse_key_seq bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (bus_if.sample !== 4'b0101) begin n_err++; $display("FAIL sparse_sample got=%b exp=0101", bus_if.sample); end
        ack();
    endtask

    task automatic test_start_ignored();
        int lat; bit to; int bad;
        logic [3:0] d;
        d = 4'($urandom_range(0, 15));
        launch(4'b0011, d);
        build_exp(4'b0011);
        collect(2, lat, to);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (lat !== 6 || to) begin n_err++; $display("FAIL ignore_latency got=%0d exp=6", lat); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ignore_key_seq bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (bus_if.sample !== (d & 4'b0011)) begin n_err++; $display("FAIL ignore_sample got=%b exp=%b", bus_if.sample, d & 4'b0011); end
        ack();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle got=%b exp=0", bus_if.busy); end
    endtask

    task automatic test_back_to_back();
        int lat; bit to; int bad;
        launch(4'b1111, 4'($urandom_range(0, 15)));
        collect(-1, lat, to);
        n_cmp++; if (lat !== 12 || to) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=12", lat); end
        bus_if.ready   = 1'b1;
        bus_if.start   = 1'b1;
        bus_if.ch_mask = 4'b0010;
        data_r         = 4'b0010;
        @(negedge clk);
        bus_if.ready = 1'b0;
        bus_if.start = 1'b0;
        n_cmp++; if (bus_if.key !== 2'd1 || bus_if.valid !== 1'b0 || bus_if.busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept got=k%0d v%b b%b exp=k1 v0 b1", bus_if.key, bus_if.valid, bus_if.busy);
        end
        build_exp(4'b0010);
        collect(-1, lat, to);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (lat !== 3 || to) begin n_err++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_key_seq bad_cycles=%0d exp=0", bad); end
        n_cmp++; if (bus_if.sample !== 4'b0010) begin n_err++; $display("FAIL b2b_sample got=%b exp=0010", bus_if.sample); end
        ack();
    endtask

    task automatic test_random();
        int lat; bit to; int bad; int hold;
        logic [3:0] m, d, exp_s;
        for (int it = 0; it < 12; it++) begin
            m     = 4'($urandom_range(1, 15));
            d     = 4'($urandom_range(0, 15));
            exp_s = m & d;
            launch(m, d);
            build_exp(m);
            collect(-1, lat, to);
            bad = 0;
            foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
            n_cmp++; if (to || lat !== $countones(m) * (SETTLE + 1)) begin
                n_err++; $display("FAIL rand_latency it=%0d mask=%b got=%0d exp=%0d", it, m, lat, $countones(m) * (SETTLE + 1));
            end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand_key_seq it=%0d mask=%b bad_cycles=%0d exp=0", it, m, bad); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) @(negedge clk);
            n_cmp++; if (bus_if.sample !== exp_s || bus_if.valid !== 1'b1) begin
                n_err++; $display("FAIL rand_sample it=%0d got=%b/%b exp=%b/1", it, bus_if.sample, bus_if.valid, exp_s);
            end
            ack();
        end
    endtask

    task automatic test_mid_reset();
        int lat; bit to; int waited;
        launch(4'b1111, 4'b1111);
        waited = 0;
        while (bus_if.key !== 2'd2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (bus_if.key !== 2'd2) begin n_err++; $display("FAIL midrst_reach_key2 got=%0d exp=2", bus_if.key); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_if.key !== 2'd0 || bus_if.valid !== 1'b0 || bus_if.sample !== 4'b0 || bus_if.busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_state got=k%0d v%b s%b b%b exp=k0 v0 s0000 b0", bus_if.key, bus_if.valid, bus_if.sample, bus_if.busy);
        end
        rst_n = 1'b1;
        launch(4'b1111, 4'b0110);
        collect(-1, lat, to);
        n_cmp++; if (lat !== 12 || to) begin n_err++; $display("FAIL midrst_latency got=%0d exp=12", lat); end
        n_cmp++; if (bus_if.sample !== 4'b0110) begin n_err++; $display("FAIL midrst_sample got=%b exp=0110", bus_if.sample); end
        ack();
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.ch_mask = 4'b0;
        bus_if.ready   = 1'b0;
        test_reset();
        test_full_scan();
        test_sparse();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
